// File: rtl/pixel_array_readout_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_readout_pkg
// Description : Shared types and constants for the pixel array readout
//               sequencer: FSM state encoding, pixel sample width and an
//               index-width helper used to size row/column counters.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_readout_pkg;

    localparam int PIXEL_BITS = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        CAPTURE = 3'd2,
        STREAM  = 3'd3,
        DONE    = 3'd4
    } readout_state_t;

    // Width of an index able to address n items, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_array_readout_if.sv
`default_nettype none
// ============================================================================
// Module      : pixel_array_readout_if
// Description : Pixel sample stream (valid/ready) between the readout
//               sequencer (master) and the downstream image interface (slave).
//   PIXEL_DATA  : 8-bit sample
//   PIXEL_ROW   : row index of the sample
//   PIXEL_COL   : column index of the sample
//   PIXEL_LAST  : final sample of the frame
//   PIXEL_VALID : sample valid
//   PIXEL_READY : downstream accepts (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_array_readout_if #(
    parameter int PIXEL_ARRAY_HEIGHT = 2,
    parameter int PIXEL_ARRAY_WIDTH  = 2
);
    import pixel_readout_pkg::*;

    localparam int ROW_W = idx_width(PIXEL_ARRAY_HEIGHT);
    localparam int COL_W = idx_width(PIXEL_ARRAY_WIDTH);

    logic [PIXEL_BITS-1:0] PIXEL_DATA;
    logic [ROW_W-1:0]      PIXEL_ROW;
    logic [COL_W-1:0]      PIXEL_COL;
    logic                  PIXEL_LAST;
    logic                  PIXEL_VALID;
    logic                  PIXEL_READY;

    modport master (
        output PIXEL_DATA, PIXEL_ROW, PIXEL_COL, PIXEL_LAST, PIXEL_VALID,
        input  PIXEL_READY
    );

    modport slave (
        input  PIXEL_DATA, PIXEL_ROW, PIXEL_COL, PIXEL_LAST, PIXEL_VALID,
        output PIXEL_READY
    );

endinterface
`default_nettype wire

// File: rtl/pixel_array_readout_row_buffer.sv
`default_nettype none
// ============================================================================
// Module      : readout_row_buffer
// Description : One row of pixels, loaded in parallel from the array data
//               bus and read back one column at a time.
//   clk     : clock
//   rst_n   : asynchronous active-low reset, clears the buffer
//   i_load  : capture i_data at the rising edge
//   i_data  : packed row, element c is column c
//   i_col   : column to present on o_pixel
//   o_pixel : buffered pixel of column i_col
// Revision    : 1.0 - initial release
// ============================================================================
module readout_row_buffer
    import pixel_readout_pkg::*;
#(
    parameter  int PIXEL_ARRAY_WIDTH = 2,
    localparam int COL_W             = idx_width(PIXEL_ARRAY_WIDTH)
) (
    input  wire logic                                         clk,
    input  wire logic                                         rst_n,
    input  wire logic                                         i_load,
    input  wire logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0] i_data,
    input  wire logic [COL_W-1:0]                             i_col,
    output logic      [PIXEL_BITS-1:0]                        o_pixel
);

    logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0] row_q;
    logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0] row_d;

    always_comb begin
        row_d = row_q;
        if (i_load) begin
            row_d = i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

    // Mux of flops only: the selected pixel depends solely on registers.
    assign o_pixel = row_q[i_col];

endmodule
`default_nettype wire

// File: rtl/pixel_array_readout.sv
`default_nettype none
// ============================================================================
// Module      : pixel_array_readout
// Description : Frame readout sequencer. Selects one array row at a time via
//               READ, waits READ_SETTLE cycles, captures DATA_IN into a row
//               buffer, then streams the row as single samples over a
//               valid/ready interface. Pulses FRAME_DONE after the last pixel.
//   CLK        : clock, rising edge
//   RESET_N    : asynchronous active-low reset
//   START      : one-cycle frame request, honoured only when idle
//   ABORT      : synchronous cancel of the current frame
//   READ       : one-hot row select to the array
//   DATA_IN    : array row data, element c is column c
//   BUSY       : high whenever not idle
//   FRAME_DONE : one-cycle pulse after the final pixel is accepted
//   pix        : pixel stream (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_array_readout
    import pixel_readout_pkg::*;
#(
    parameter int PIXEL_ARRAY_HEIGHT = 2,
    parameter int PIXEL_ARRAY_WIDTH  = 2,
    parameter int READ_SETTLE        = 1
) (
    input  wire logic                                         CLK,
    input  wire logic                                         RESET_N,
    input  wire logic                                         START,
    input  wire logic                                         ABORT,
    output logic      [PIXEL_ARRAY_HEIGHT-1:0]                READ,
    input  wire logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0] DATA_IN,
    output logic                                              BUSY,
    output logic                                              FRAME_DONE,
    pixel_array_readout_if.master                             pix
);

    localparam int ROW_W = idx_width(PIXEL_ARRAY_HEIGHT);
    localparam int COL_W = idx_width(PIXEL_ARRAY_WIDTH);
    localparam int SET_W = idx_width(READ_SETTLE);

    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST    = COL_W'(PIXEL_ARRAY_WIDTH - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(READ_SETTLE - 1);

    readout_state_t                state_q, state_d;
    logic [ROW_W-1:0]              row_q, row_d;
    logic [COL_W-1:0]              col_q, col_d;
    logic [SET_W-1:0]              settle_q, settle_d;
    logic [PIXEL_ARRAY_HEIGHT-1:0] read_q, read_d;
    logic                          valid_q, valid_d;
    logic                          last_q, last_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          load;
    logic [PIXEL_BITS-1:0]         pixel;

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        settle_d = settle_q;
        load     = 1'b0;

        if (state_q == IDLE) begin
            // ABORT wins over a coincident START.
            if (START && !ABORT) begin
                state_d  = SELECT;
                row_d    = '0;
                col_d    = '0;
                settle_d = '0;
            end
        end else if (ABORT) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                SELECT: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = CAPTURE;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                CAPTURE: begin
                    load    = 1'b1;
                    col_d   = '0;
                    state_d = STREAM;
                end
                STREAM: begin
                    if (valid_q && pix.PIXEL_READY) begin
                        if (col_q != COL_LAST) begin
                            col_d = col_q + 1'b1;
                        end else if (row_q != ROW_LAST) begin
                            row_d    = row_q + 1'b1;
                            settle_d = '0;
                            state_d  = SELECT;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs are decoded from the next state so that every output comes
    // straight from a flop in the cycle that state is active.
    // ------------------------------------------------------------------
    always_comb begin
        read_d = '0;
        if (state_d == SELECT || state_d == CAPTURE) begin
            read_d[row_d] = 1'b1;
        end
        valid_d = (state_d == STREAM);
        last_d  = valid_d && (row_d == ROW_LAST) && (col_d == COL_LAST);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            settle_q <= '0;
            read_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            settle_q <= settle_d;
            read_q   <= read_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    readout_row_buffer #(
        .PIXEL_ARRAY_WIDTH (PIXEL_ARRAY_WIDTH)
    ) u_row_buffer (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .i_load  (load),
        .i_data  (DATA_IN),
        .i_col   (col_q),
        .o_pixel (pixel)
    );

    assign READ            = read_q;
    assign BUSY            = busy_q;
    assign FRAME_DONE      = done_q;
    assign pix.PIXEL_DATA  = pixel;
    assign pix.PIXEL_ROW   = row_q;
    assign pix.PIXEL_COL   = col_q;
    assign pix.PIXEL_LAST  = last_q;
    assign pix.PIXEL_VALID = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_array_readout.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_array_readout
// Description : Self-checking bench for pixel_array_readout (H=2, W=2,
//               READ_SETTLE=1). Frames of random pixel images are read out
//               under random backpressure; the streamed samples are compared
//               with the image, plus directed timing, abort and reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_array_readout;

    localparam int H  = 2;
    localparam int W  = 2;
    localparam int RS = 1;

    logic                 CLK;
    logic                 RESET_N;
    logic                 START;
    logic                 ABORT;
    logic [H-1:0]         READ;
    logic [W-1:0][7:0]    DATA_IN;
    logic                 BUSY;
    logic                 FRAME_DONE;

    pixel_array_readout_if #(
        .PIXEL_ARRAY_HEIGHT (H),
        .PIXEL_ARRAY_WIDTH  (W)
    ) pif ();

    pixel_array_readout #(
        .PIXEL_ARRAY_HEIGHT (H),
        .PIXEL_ARRAY_WIDTH  (W),
        .READ_SETTLE        (RS)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .START      (START),
        .ABORT      (ABORT),
        .READ       (READ),
        .DATA_IN    (DATA_IN),
        .BUSY       (BUSY),
        .FRAME_DONE (FRAME_DONE),
        .pix        (pif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] d;
        int         r;
        int         c;
        bit         last;
    } xfer_t;

    int           n_checks = 0;
    int           n_pass   = 0;
    bit   [7:0]   img [H][W];
    xfer_t        xq [$];
    logic [H-1:0] log_read [$];
    bit           log_busy [$];
    bit           log_done [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_image();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read"},  32'(READ), 0);
        check({tag, "_valid"}, 32'(pif.PIXEL_VALID), 0);
        check({tag, "_last"},  32'(pif.PIXEL_LAST), 0);
        check({tag, "_done"},  32'(FRAME_DONE), 0);
        check({tag, "_busy"},  32'(BUSY), 0);
        check({tag, "_data"},  32'(pif.PIXEL_DATA), 0);
        check({tag, "_row"},   32'(pif.PIXEL_ROW), 0);
        check({tag, "_col"},   32'(pif.PIXEL_COL), 0);
    endtask

    // Runs one frame from START to FRAME_DONE. The array model drives the
    // selected row's pixels only in the cycle where READ has been high for
    // RS+1 cycles (the capture cycle) and random garbage otherwise.
    // stall_first: READY held low for that many cycles while VALID is high.
    // restart_cyc: cycle in which a second START is pulsed (0 = none).
    task automatic run_frame(input int ready_pct, input int stall_first, input int restart_cyc);
        int         cyc;
        int         read_run;
        int         stall;
        int         sel;
        bit         prev_stall;
        logic [7:0] pd;
        logic [31:0] pr, pc;
        bit         pl;
        bit         rdy;
        xq.delete();
        log_read.delete();
        log_busy.delete();
        log_done.delete();
        stall      = stall_first;
        read_run   = 0;
        prev_stall = 0;
        pd = '0; pr = '0; pc = '0; pl = 0;
        START = 1'b1;
        step();
        START = 1'b0;
        cyc = 1;
        while (cyc < 200) begin
            log_read.push_back(READ);
            log_busy.push_back(BUSY);
            log_done.push_back(FRAME_DONE);
            check("read_onehot_no_valid",
                  32'($onehot0(READ) && !((|READ) && pif.PIXEL_VALID)), 1);
            if (prev_stall) begin
                check("hold_valid", 32'(pif.PIXEL_VALID), 1);
                check("hold_data",  32'(pif.PIXEL_DATA), 32'(pd));
                check("hold_row",   32'(pif.PIXEL_ROW), pr);
                check("hold_col",   32'(pif.PIXEL_COL), pc);
                check("hold_last",  32'(pif.PIXEL_LAST), 32'(pl));
            end
            read_run = (|READ) ? read_run + 1 : 0;
            DATA_IN  = W*8'($urandom);
            if (read_run == RS + 1) begin
                sel = 0;
                for (int r = 0; r < H; r++) if (READ[r]) sel = r;
                for (int c = 0; c < W; c++) DATA_IN[c] = img[sel][c];
            end
            if (pif.PIXEL_VALID && stall > 0) begin
                rdy = 1'b0;
                stall--;
            end else begin
                rdy = ($urandom_range(99) < ready_pct);
            end
            pif.PIXEL_READY = rdy;
            if (pif.PIXEL_VALID && rdy) begin
                xq.push_back('{d: pif.PIXEL_DATA, r: int'(pif.PIXEL_ROW),
                               c: int'(pif.PIXEL_COL), last: pif.PIXEL_LAST});
            end
            prev_stall = pif.PIXEL_VALID && !rdy;
            pd = pif.PIXEL_DATA;
            pr = 32'(pif.PIXEL_ROW);
            pc = 32'(pif.PIXEL_COL);
            pl = pif.PIXEL_LAST;
            if (FRAME_DONE) break;
            START = (cyc + 1 == restart_cyc);
            step();
            START = 1'b0;
            cyc++;
        end
        check("frame_done_seen", 32'(cyc < 200), 1);
        pif.PIXEL_READY = 1'b0;
    endtask

    // Expected stream is simply the image in raster order.
    task automatic verify_frame();
        int n;
        check("xfer_count", 32'(xq.size()), H*W);
        n = (xq.size() < H*W) ? xq.size() : H*W;
        for (int i = 0; i < n; i++) begin
            check("xfer_data", 32'(xq[i].d), 32'(img[i / W][i % W]));
            check("xfer_row",  32'(xq[i].r), 32'(i / W));
            check("xfer_col",  32'(xq[i].c), 32'(i % W));
            check("xfer_last", 32'(xq[i].last), 32'(i == H*W - 1));
        end
    endtask

    initial begin
        int ndone;
        logic [H-1:0] exp_read;
        RESET_N = 1'b0;
        START   = 1'b0;
        ABORT   = 1'b0;
        DATA_IN = '0;
        pif.PIXEL_READY = 1'b0;
        step();
        step();
        check_all_zero("reset");
        RESET_N = 1'b1;
        step();
        check("idle_busy", 32'(BUSY), 0);

        // Directed full frame with READY tied high.
        img[0][0] = 8'hA1; img[0][1] = 8'hB2;
        img[1][0] = 8'hC3; img[1][1] = 8'hD4;
        run_frame(100, 0, 0);
        verify_frame();
        check("frame_len", 32'(log_read.size()), H*(RS+1+W)+1);
        if (log_read.size() == 9) begin
            for (int k = 0; k < 9; k++) begin
                exp_read = (k == 0 || k == 1) ? 2'b01 :
                           (k == 4 || k == 5) ? 2'b10 : 2'b00;
                check($sformatf("timeline_read_c%0d", k + 1), 32'(log_read[k]), 32'(exp_read));
                check($sformatf("timeline_busy_c%0d", k + 1), 32'(log_busy[k]), 1);
                check($sformatf("timeline_done_c%0d", k + 1), 32'(log_done[k]), 32'(k == 8));
            end
        end
        step();
        check("after_frame_busy", 32'(BUSY), 0);
        check("after_frame_done", 32'(FRAME_DONE), 0);

        // Backpressure: A1 held for three cycles.
        run_frame(100, 3, 0);
        verify_frame();
        check("bp_frame_len", 32'(log_read.size()), H*(RS+1+W)+1+3);
        step();

        // Second START while busy is dropped.
        rand_image();
        run_frame(100, 0, 3);
        verify_frame();
        ndone = 0;
        foreach (log_done[k]) ndone += int'(log_done[k]);
        check("restart_done_count", 32'(ndone), 1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("restart_no_second_frame", 32'({BUSY, FRAME_DONE}), 0);
        end

        // ABORT in STREAM after A1 accepted.
        img[0][0] = 8'hA1; img[0][1] = 8'hB2;
        img[1][0] = 8'hC3; img[1][1] = 8'hD4;
        DATA_IN = {8'hB2, 8'hA1};
        pif.PIXEL_READY = 1'b1;
        START = 1'b1;
        step();
        START = 1'b0;
        step();
        step();
        check("abort_a1_valid", 32'(pif.PIXEL_VALID), 1);
        check("abort_a1_data",  32'(pif.PIXEL_DATA), 32'h A1);
        step();
        check("abort_b2_valid", 32'(pif.PIXEL_VALID), 1);
        pif.PIXEL_READY = 1'b0;
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        check("abort_valid", 32'(pif.PIXEL_VALID), 0);
        check("abort_read",  32'(READ), 0);
        check("abort_busy",  32'(BUSY), 0);
        check("abort_done",  32'(FRAME_DONE), 0);
        step();
        check("abort_no_done_later", 32'(FRAME_DONE), 0);
        // START together with ABORT in IDLE stays idle.
        START = 1'b1;
        ABORT = 1'b1;
        step();
        START = 1'b0;
        ABORT = 1'b0;
        check("start_abort_busy", 32'(BUSY), 0);
        check("start_abort_read", 32'(READ), 0);
        run_frame(100, 0, 0);
        verify_frame();
        step();

        // Asynchronous reset during SELECT of row 1.
        DATA_IN = '0;
        pif.PIXEL_READY = 1'b1;
        START = 1'b1;
        step();
        START = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("rst_pre_read_row1", 32'(READ), 32'(2'b10));
        #2;
        RESET_N = 1'b0;
        #1;
        check_all_zero("async_rst");
        step();
        RESET_N = 1'b1;
        pif.PIXEL_READY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_rst_idle", 32'({BUSY, pif.PIXEL_VALID, READ, FRAME_DONE}), 0);
        end

        // Random images under random backpressure.
        for (int f = 0; f < 6; f++) begin
            rand_image();
            run_frame(int'($urandom_range(100, 30)), int'($urandom_range(3)), 0);
            verify_frame();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_array_readout.md
# pixel_array_readout

Frame readout sequencer for the pixel array. It drives the per-row `READ` select lines one row at a time and captures the row's packed `DATA_OUT` bus into a local row buffer. It then streams the captured pixels out as single 8-bit samples over a valid/ready handshake. It sits between the pixel array and the downstream image interface, and is started by the top-level camera state machine once conversion of a frame is complete.

## Interface
Parameters:
- `PIXEL_ARRAY_HEIGHT`, 2, number of rows; width of `READ`.
- `PIXEL_ARRAY_WIDTH`, 2, pixels per row.
- `READ_SETTLE`, 1, cycles `READ` is held before capture (≥1).

Ports:
- `CLK`  in  1  clock; all logic on rising edge.
- `RESET_N`  in  1  reset, asynchronous assert, active-low.
- `START`  in  1  one-cycle request to read a frame; honoured only in IDLE.
- `ABORT`  in  1  synchronous cancel of the current frame.
- `READ`  out  `PIXEL_ARRAY_HEIGHT`  one-hot row select to the array; all-zero when no row is selected.
- `DATA_IN`  in  `[PIXEL_ARRAY_WIDTH-1:0][7:0]`  array `DATA_OUT`; element c is column c.
- `PIXEL_DATA`  out  8  current pixel sample.
- `PIXEL_ROW`  out  `$clog2(max(H,2))`  row index of `PIXEL_DATA`.
- `PIXEL_COL`  out  `$clog2(max(W,2))`  column index of `PIXEL_DATA`.
- `PIXEL_LAST`  out  1  high with the final pixel of the frame.
- `PIXEL_VALID`  out  1  sample valid.
- `PIXEL_READY`  in  1  downstream accepts.
- `BUSY`  out  1  high in every state except IDLE.
- `FRAME_DONE`  out  1  one-cycle pulse after the last pixel is accepted.

## Operation
States:
- **IDLE:** `READ`=0, `VALID`=0, `BUSY`=0. `START` moves to SELECT with row=0.
- **SELECT:** `READ[row]`=1. Settle counter counts `READ_SETTLE` cycles, then moves to CAPTURE.
- **CAPTURE:** `READ[row]` stays 1. Row buffer ← `DATA_IN` at the cycle-end edge. Column=0. Moves to STREAM.
- **STREAM:** `READ`=0, `VALID`=1, `PIXEL_DATA`=buffer[col].
  - A transfer occurs on an edge with `VALID`&`READY`.
  - On transfer with col<W-1: col+1.
  - On transfer with col=W-1 and row<H-1: row+1, go to SELECT.
  - On transfer with col=W-1 and row=H-1: go to DONE.
- **DONE:** `FRAME_DONE`=1 for one cycle, then IDLE.

Boundary and handshake rules:
- `PIXEL_LAST` = (row=H-1 && col=W-1) in STREAM.
- While `VALID`=1 and not accepted, `PIXEL_DATA`/`ROW`/`COL`/`LAST` hold stable. `VALID` never drops without a transfer, except on `ABORT` or reset.
- Row and column counters never wrap past H-1/W-1. `READ` is never multi-hot.
- `START` outside IDLE is ignored (no queueing). `START` coinciding with `ABORT` in IDLE: `ABORT` wins, stay IDLE.
- `ABORT` in any non-IDLE state moves to IDLE on the next edge, with `READ`=0 and `VALID`=0. No `FRAME_DONE`; the buffer is left as is.
- `DATA_IN` is sampled only in CAPTURE; it is don't-care elsewhere.

Reset (`RESET_N`=0) immediately forces:
- state=IDLE
- `READ`=0, `PIXEL_VALID`=0, `PIXEL_LAST`=0, `FRAME_DONE`=0, `BUSY`=0
- `PIXEL_DATA`=0, `PIXEL_ROW`=0, `PIXEL_COL`=0
- row buffer=0

Reset asserted mid-frame abandons the frame with no `FRAME_DONE`.

## Timing
- `START` sampled at edge 0 → `READ[0]` high in cycles 1..`READ_SETTLE`+1. Capture occurs at the edge ending cycle `READ_SETTLE`+1. First `VALID` is in cycle `READ_SETTLE`+2.
- Row cycle with `READY` tied high: `READ_SETTLE`+1+W cycles.
- Frame cycle count: H·(`READ_SETTLE`+1+W)+1, including DONE.
- Next row's `READ` asserts in the cycle after the last column's transfer.
- All outputs are registered; no combinational path from `PIXEL_READY` to any output.

## Structure
- Shared package `pixel_readout_pkg`:
  - state enum `readout_state_t` {IDLE, SELECT, CAPTURE, STREAM, DONE}
  - pixel width constant `PIXEL_BITS`=8
- Sub-module `readout_row_buffer`: W×8 parallel-load register with column-indexed read. Holds the load enable, the column mux and the reset clear.
- Top level holds the FSM, the row/column/settle counters and the handshake registers.

## Test plan
H=2, W=2, `READ_SETTLE`=1 throughout.
- **Full frame, `READY`=1.** Row 0 `DATA_IN`={B2,A1}, row 1 {D4,C3}. START → stream A1,B2,C3,D4 with (row,col)=(0,0),(0,1),(1,0),(1,1). `PIXEL_LAST` only on D4. `READ`=01 in cycles 1–2 and 10 in cycles 5–6. `FRAME_DONE` in cycle 9. BUSY cycles 1–9.
- **Backpressure.** `READY`=0 for 3 cycles while A1 is presented → A1/row/col held stable, `VALID` stays 1, no `READ` asserted. Stream resumes with B2 after `READY`=1.
- **START while BUSY.** Second START in cycle 3 → ignored; exactly one frame is produced and one `FRAME_DONE`.
- **ABORT.** ABORT in STREAM after A1 is accepted → next cycle IDLE, `VALID`=0, `READ`=00, no `FRAME_DONE`. A fresh START then yields A1 first.
- **Async reset mid-frame.** `RESET_N` low during SELECT of row 1 → all outputs 0 immediately, without waiting for a clock edge. After release, state is IDLE until START.
- **Capture isolation.** Change `DATA_IN` outside CAPTURE cycles → streamed values equal those present in the capture cycle only.
